// File: rtl/binary_matrix_power_seq.sv
// Iterates y = M*x over GF(2) for K steps (or to the first fixed point) and returns M^K*v.
// Latency min(K,F)+1 cycles from acceptance; one request in flight, result held in DONE until out_ready.
module binary_matrix_power_seq #(
  parameter int CNT_W      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_mat,
  input  logic [1:0]       in_vec,
  input  logic [CNT_W-1:0] in_k,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_vec,
  output logic [CNT_W-1:0] out_steps,
  output logic             out_fixed
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       mat_q, mat_d;
  logic [1:0]       x_q, x_d;
  logic [CNT_W-1:0] k_q, k_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       out_vec_q, out_vec_d;
  logic [CNT_W-1:0] out_steps_q, out_steps_d;
  logic             out_fixed_q, out_fixed_d;

  logic [1:0]       y;
  logic [1:0]       y_next;
  logic [1:0]       in_prod;
  logic [CNT_W-1:0] count_inc;

  // bit0 of the product is row 0 (a,b), bit1 is row 1 (c,d)
  function automatic logic [1:0] gf2_mul(input logic [3:0] m, input logic [1:0] v);
    logic [1:0] r;
    r[0] = (m[0] & v[0]) ^ (m[1] & v[1]);
    r[1] = (m[2] & v[0]) ^ (m[3] & v[1]);
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    mat_d       = mat_q;
    x_d         = x_q;
    k_d         = k_q;
    count_d     = count_q;
    out_vec_d   = out_vec_q;
    out_steps_d = out_steps_q;
    out_fixed_d = out_fixed_q;

    y         = gf2_mul(mat_q, x_q);
    y_next    = gf2_mul(mat_q, y);
    in_prod   = gf2_mul(in_mat, in_vec);
    count_inc = count_q + {{(CNT_W-1){1'b0}}, 1'b1};

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mat_d   = in_mat;
          x_d     = in_vec;
          k_d     = in_k;
          count_d = '0;
          if (in_k == '0) begin
            state_d     = DONE;
            out_vec_d   = in_vec;
            out_steps_d = '0;
            out_fixed_d = (in_prod == in_vec);
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        x_d     = y;
        count_d = count_inc;
        // count_inc never passes k_q, so the counter cannot wrap
        if ((count_inc == k_q) || (EARLY_EXIT && (y == x_q))) begin
          state_d     = DONE;
          out_vec_d   = y;
          out_steps_d = count_inc;
          out_fixed_d = (y_next == y);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mat_q       <= '0;
      x_q         <= '0;
      k_q         <= '0;
      count_q     <= '0;
      out_vec_q   <= '0;
      out_steps_q <= '0;
      out_fixed_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mat_q       <= mat_d;
      x_q         <= x_d;
      k_q         <= k_d;
      count_q     <= count_d;
      out_vec_q   <= out_vec_d;
      out_steps_q <= out_steps_d;
      out_fixed_q <= out_fixed_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_vec   = out_vec_q;
  assign out_steps = out_steps_q;
  assign out_fixed = out_fixed_q;

endmodule
